// File: rtl/program_loader.sv
// Program RAM loader: parses a framed byte stream (sync, length, words, XOR checksum),
// writes 16-bit words from address 0 and holds the CPU in reset until a load verifies.
module program_loader #(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      SYNC    = 8'hA5;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LEN_HI  = 3'd1;
   localparam logic [2:0] ST_LEN_LO  = 3'd2;
   localparam logic [2:0] ST_DATA_HI = 3'd3;
   localparam logic [2:0] ST_DATA_LO = 3'd4;
   localparam logic [2:0] ST_CHECK   = 3'd5;
   localparam logic [2:0] ST_FINISH  = 3'd6;
   localparam logic [2:0] ST_ABORT   = 3'd7;

   logic [2:0]        state_q,     state_d;
   logic [15:0]       rem_q,       rem_d;
   logic [ADDR_W-1:0] idx_q,       idx_d;
   logic [7:0]        hi_q,        hi_d;
   logic [7:0]        xacc_q,      xacc_d;
   logic [TO_W-1:0]   to_q,        to_d;
   logic              in_ready_q,  in_ready_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_rst_q,   cpu_rst_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic              error_q,     error_d;
   logic              xfer;
   logic              in_frame;
   logic              timed_out;

   // Ready and the write strobe are masked by rst so a pending write never escapes a reset.
   assign in_ready  = in_ready_q & ~rst;
   assign mem_we    = mem_we_q & ~rst;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst   = cpu_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

   // Frame parser, timeout supervision and registered output generation.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      idx_d       = idx_q;
      hi_d        = hi_q;
      xacc_d      = xacc_q;
      to_d        = to_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rst_d   = cpu_rst_q;

      xfer      = in_valid && in_ready;
      in_frame  = (state_q != ST_IDLE) && (state_q != ST_FINISH) && (state_q != ST_ABORT);
      timed_out = in_frame && !xfer && (to_q == TO_LAST);

      if (state_q != ST_IDLE) begin
         to_d = xfer ? '0 : to_q + TO_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (xfer && (in_data == SYNC)) begin
               state_d   = ST_LEN_HI;
               cpu_rst_d = 1'b1;
               idx_d     = '0;
               xacc_d    = '0;
               to_d      = '0;
            end
         end
         ST_LEN_HI: begin
            if (xfer) begin
               rem_d   = {in_data, rem_q[7:0]};
               state_d = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (xfer) begin
               rem_d   = {rem_q[15:8], in_data};
               state_d = ({rem_q[15:8], in_data} == 16'd0) ? ST_CHECK : ST_DATA_HI;
            end
         end
         ST_DATA_HI: begin
            if (xfer) begin
               hi_d    = in_data;
               xacc_d  = xacc_q ^ in_data;
               state_d = ST_DATA_LO;
            end
         end
         ST_DATA_LO: begin
            if (xfer) begin
               xacc_d      = xacc_q ^ in_data;
               mem_we_d    = 1'b1;
               mem_addr_d  = idx_q;
               mem_wdata_d = {hi_q, in_data};
               idx_d       = idx_q + ADDR_W'(1);
               rem_d       = rem_q - 16'd1;
               state_d     = (rem_q == 16'd1) ? ST_CHECK : ST_DATA_HI;
            end
         end
         ST_CHECK: begin
            if (xfer) begin
               state_d = (in_data == xacc_q) ? ST_FINISH : ST_ABORT;
            end
         end
         ST_FINISH: begin
            state_d   = ST_IDLE;
            cpu_rst_d = 1'b0;
         end
         ST_ABORT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A byte accepted on the expiry cycle clears the counter, so timed_out already excludes it.
      if (timed_out) begin
         state_d = ST_ABORT;
      end
      if (state_d == ST_IDLE) begin
         to_d = '0;
      end

      done_d     = (state_d == ST_FINISH);
      error_d    = (state_d == ST_ABORT);
      busy_d     = (state_d != ST_IDLE);
      in_ready_d = !(mem_we_d || (state_d == ST_FINISH) || (state_d == ST_ABORT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rem_q       <= '0;
         idx_q       <= '0;
         hi_q        <= '0;
         xacc_q      <= '0;
         to_q        <= '0;
         in_ready_q  <= 1'b1;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rst_q   <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         idx_q       <= idx_d;
         hi_q        <= hi_d;
         xacc_q      <= xacc_d;
         to_q        <= to_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rst_q   <= cpu_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: frame-level reference model checked every cycle,
// directed frames with literal expectations, then randomized frames with gaps and faults.
module tb_program_loader;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned TMO    = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              cpu_rst;
   logic              busy;
   logic              done;
   logic              error;

   always #5 clk = ~clk;

   program_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
      .busy(busy), .done(done), .error(error)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Reference model: position within the frame, counted in accepted bytes.
   bit          m_busy, m_we, m_done, m_err, m_cpu_rst, m_prev_rst;
   int          m_pos, m_len, m_idle;
   logic [7:0]  m_hi, m_xor;
   logic [15:0] m_waddr, m_wdata;

   int          n_we = 0, n_done = 0, n_err = 0;
   logic [15:0] wq_addr[$];
   logic [15:0] wq_data[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_busy = 0; m_we = 0; m_done = 0; m_err = 0; m_cpu_rst = 1;
      m_pos = 0; m_len = 0; m_idle = 0; m_hi = 0; m_xor = 0;
      m_waddr = 0; m_wdata = 0;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_rdy, xf, nwe, ndone, nerr;
         int k;
         if (rst) begin
            chk("in_ready_in_rst", in_ready, 0);
            chk("mem_we_in_rst", mem_we, 0);
            if (m_prev_rst) begin
               chk("cpu_rst_in_rst", cpu_rst, 1);
               chk("busy_in_rst", busy, 0);
               chk("done_in_rst", done, 0);
               chk("error_in_rst", error, 0);
               chk("mem_addr_in_rst", 32'(mem_addr), 0);
               chk("mem_wdata_in_rst", 32'(mem_wdata), 0);
            end
            model_reset();
            m_prev_rst = 1;
         end else begin
            m_prev_rst = 0;
            exp_rdy = !(m_we || m_done || m_err);
            chk("in_ready", in_ready, 32'(exp_rdy));
            chk("mem_we", mem_we, 32'(m_we));
            chk("busy", busy, 32'(m_busy));
            chk("done", done, 32'(m_done));
            chk("error", error, 32'(m_err));
            chk("cpu_rst", cpu_rst, 32'(m_cpu_rst));
            chk("mem_addr", 32'(mem_addr), 32'(m_waddr));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            if (mem_we) begin
               n_we++;
               wq_addr.push_back(mem_addr);
               wq_data.push_back(mem_wdata);
            end
            if (done) n_done++;
            if (error) n_err++;

            xf = in_valid && exp_rdy;
            nwe = 0; ndone = 0; nerr = 0;
            if (m_done) begin
               m_busy = 0;
               m_cpu_rst = 0;
            end else if (m_err) begin
               m_busy = 0;
            end else if (!m_busy) begin
               if (xf && in_data == 8'hA5) begin
                  m_busy = 1; m_pos = 1; m_cpu_rst = 1; m_xor = 0; m_idle = 0; m_len = 0;
               end
            end else if (xf) begin
               m_idle = 0;
               if (m_pos == 1) m_len = int'(in_data) * 256;
               else if (m_pos == 2) m_len = m_len + int'(in_data);
               else begin
                  k = m_pos - 3;
                  if (k < 2 * m_len) begin
                     m_xor = m_xor ^ in_data;
                     if (k % 2 == 0) m_hi = in_data;
                     else begin
                        nwe = 1;
                        m_waddr = 16'(k / 2);
                        m_wdata = {m_hi, in_data};
                     end
                  end else if (in_data == m_xor) ndone = 1;
                  else nerr = 1;
               end
               m_pos++;
            end else begin
               m_idle++;
               if (m_idle >= int'(TMO)) nerr = 1;
            end
            m_we = nwe; m_done = ndone; m_err = nerr;
         end
      end
   end

   // All driver tasks start and end at posedge+1.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      int w;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = b;
      ok = 0;
      w  = 0;
      while (!ok && w < 64) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk); #1;
         w++;
      end
      chk("byte_accepted", 32'(ok), 1);
      in_valid = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] b[$], input int gmax);
      foreach (b[i]) send_byte(b[i], int'($urandom_range(0, gmax)));
   endtask

   task automatic send_frame(input logic [15:0] w[$], input bit bad, input int gmax,
                             input int cut);
      logic [7:0] b[$];
      logic [7:0] x;
      int n;
      x = 8'h00;
      b.push_back(8'hA5);
      b.push_back(8'(w.size() >> 8));
      b.push_back(8'(w.size()));
      foreach (w[i]) begin
         b.push_back(w[i][15:8]);
         b.push_back(w[i][7:0]);
         x = x ^ w[i][15:8] ^ w[i][7:0];
      end
      b.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
      n = (cut > 0) ? cut : b.size();
      for (int i = 0; i < n; i++) send_byte(b[i], int'($urandom_range(0, gmax)));
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_write(input string name, input int idx, input logic [15:0] a,
                            input logic [15:0] d);
      if (idx < wq_addr.size()) begin
         chk({name, "_addr"}, 32'(wq_addr[idx]), 32'(a));
         chk({name, "_data"}, 32'(wq_data[idx]), 32'(d));
      end else begin
         chk({name, "_present"}, 32'(wq_addr.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  bq[$];
      logic [15:0] wv[$];
      int b_we, b_done, b_err, b_wq, i, exp_done, exp_err;
      bit bad, cut_it;
      int len, cut;

      rst = 1'b1;
      @(posedge clk); #1;
      model_reset();
      m_prev_rst = 1;
      chk_en = 1'b1;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);
      chk("cpu_rst_after_rst", cpu_rst, 1);
      @(posedge clk); #1;

      // Good load
      b_we = n_we; b_done = n_done; b_err = n_err; b_wq = wq_addr.size();
      bq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      send_bytes(bq, 0);
      idle(3);
      chk("good_we_count", 32'(n_we - b_we), 2);
      chk_write("good_w0", b_wq, 16'h0000, 16'h1234);
      chk_write("good_w1", b_wq + 1, 16'h0001, 16'hABCD);
      chk("good_done", 32'(n_done - b_done), 1);
      chk("good_error", 32'(n_err - b_err), 0);
      chk("good_cpu_released", cpu_rst, 0);

      // Junk skipping, empty frame, cpu_rst reassertion on a new sync
      b_we = n_we; b_done = n_done;
      send_byte(8'h00, 0);
      send_byte(8'hFF, 1);
      chk("junk_not_busy", busy, 0);
      send_byte(8'hA5, 0);
      @(negedge clk);
      chk("sync_reasserts_cpu_rst", cpu_rst, 1);
      @(posedge clk); #1;
      bq = '{8'h00, 8'h00, 8'h00};
      send_bytes(bq, 0);
      idle(3);
      chk("empty_we_count", 32'(n_we - b_we), 0);
      chk("empty_done", 32'(n_done - b_done), 1);

      // Bad checksum
      b_we = n_we; b_done = n_done; b_err = n_err; b_wq = wq_addr.size();
      bq = '{8'hA5, 8'h00, 8'h01, 8'h70, 8'h1F, 8'h00};
      send_bytes(bq, 0);
      idle(3);
      chk("bad_we_count", 32'(n_we - b_we), 1);
      chk_write("bad_w0", b_wq, 16'h0000, 16'h701F);
      chk("bad_error", 32'(n_err - b_err), 1);
      chk("bad_done", 32'(n_done - b_done), 0);
      chk("bad_cpu_held", cpu_rst, 1);

      // Timeout after a partial frame, then a normal load
      bq = '{8'hA5, 8'h00, 8'h02, 8'h12};
      send_bytes(bq, 0);
      i = 0;
      while (i < 40) begin
         @(negedge clk);
         i++;
         if (error) break;
      end
      chk("timeout_cycle", 32'(i), TMO + 1);
      @(negedge clk);
      chk("timeout_busy_low", busy, 0);
      @(posedge clk); #1;
      b_we = n_we; b_done = n_done; b_wq = wq_addr.size();
      bq = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
      send_bytes(bq, 0);
      idle(3);
      chk_write("post_timeout_w0", b_wq, 16'h0000, 16'hBEEF);
      chk("post_timeout_done", 32'(n_done - b_done), 1);

      // Four-word load with random gaps below the timeout
      b_we = n_we; b_done = n_done; b_wq = wq_addr.size();
      wv.delete();
      for (int j = 0; j < 4; j++) wv.push_back(16'($urandom));
      send_frame(wv, 1'b0, 9, 0);
      idle(3);
      chk("gaps_we_count", 32'(n_we - b_we), 4);
      for (int j = 0; j < 4; j++) chk_write("gaps_w", b_wq + j, 16'(j), wv[j]);
      chk("gaps_done", 32'(n_done - b_done), 1);

      // Reset while the write for a just-accepted LO byte is pending
      b_we = n_we;
      bq = '{8'hA5, 8'h00, 8'h02, 8'h12};
      send_bytes(bq, 0);
      in_valid = 1'b1;
      in_data  = 8'h34;
      @(posedge clk); #1;
      rst = 1'b1;
      in_valid = 1'b0;
      idle(2);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_no_write", 32'(n_we - b_we), 0);
      chk("rst_mid_cpu_rst", cpu_rst, 1);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready", in_ready, 1);
      @(posedge clk); #1;

      // Randomized frames: junk, gaps, bad checksums, abandoned frames
      exp_done = 0; exp_err = 0;
      b_done = n_done; b_err = n_err;
      for (int f = 0; f < 25; f++) begin
         int nj;
         nj = int'($urandom_range(0, 2));
         for (int j = 0; j < nj; j++) begin
            logic [7:0] jb;
            jb = 8'($urandom);
            if (jb == 8'hA5) jb = 8'h5A;
            send_byte(jb, int'($urandom_range(0, 3)));
         end
         len = int'($urandom_range(0, 5));
         wv.delete();
         for (int j = 0; j < len; j++) wv.push_back(16'($urandom));
         bad    = ($urandom_range(0, 3) == 0);
         cut_it = ($urandom_range(0, 5) == 0);
         cut    = cut_it ? int'($urandom_range(1, 3 + 2 * len)) : 0;
         send_frame(wv, bad, 6, cut);
         if (cut_it) begin
            exp_err++;
            idle(TMO + 4);
         end else begin
            if (bad) exp_err++;
            else exp_done++;
            idle(int'($urandom_range(1, 4)));
         end
      end
      idle(3);
      chk("rand_done_count", 32'(n_done - b_done), 32'(exp_done));
      chk("rand_error_count", 32'(n_err - b_err), 32'(exp_err));

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
